// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory arbiter and its helpers.
package mem_pkg;

   localparam int BLOCK_WORDS = 8;
   localparam int OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_FILL  = 2'd1,
      D_FILL  = 2'd2,
      D_WRITE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/burst_counter.sv
// Clearable up-counter used to track issued and returned words of a block burst.
module burst_counter #(
   parameter int WIDTH    = 4,
   parameter int LAST_VAL = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == WIDTH'(LAST_VAL));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between I-cache fills and D-cache
// fills/writes, with fixed priority to the I-cache and no preemption.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int WORDS       = BLOCK_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_data_valid,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [15:0] rd_data,
   output logic [2:0]  word_idx,
   output logic        i_data_valid,
   output logic        d_data_valid,
   output logic        i_done,
   output logic        d_done,
   output logic        waitForICACHE
);

   localparam int IDXW  = $clog2(WORDS);
   localparam int CW    = IDXW + 1;
   localparam int BASEW = 16 - OFFSET_BITS;

   if (MEM_LATENCY < 1 || (WORDS & (WORDS - 1)) != 0 || IDXW + 1 != OFFSET_BITS) begin : g_bad_params
      $error("mem_arbiter: inconsistent MEM_LATENCY/WORDS parameters");
   end

   arb_state_t       state_q, state_d;
   logic [BASEW-1:0] base_q;
   logic [CW-1:0]    ic, rc;
   logic             ic_last, rc_last;
   logic             in_fill, issuing, fill_done;

   assign in_fill   = (state_q == I_FILL) || (state_q == D_FILL);
   assign issuing   = in_fill && !ic_last;
   assign fill_done = in_fill && mem_data_valid && rc_last;

   // ic stops at WORDS (all reads issued); rc terminates on the final returning word
   burst_counter #(.WIDTH(CW), .LAST_VAL(WORDS)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fill_done),
      .inc   (issuing),
      .count (ic),
      .last  (ic_last)
   );

   burst_counter #(.WIDTH(CW), .LAST_VAL(WORDS - 1)) u_return_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fill_done),
      .inc   (in_fill && mem_data_valid),
      .count (rc),
      .last  (rc_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The block base is captured every idle cycle so it is valid on grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
      end else if (state_q == IDLE) begin
         base_q <= i_req ? i_addr[15:OFFSET_BITS] : d_addr[15:OFFSET_BITS];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (i_req) begin
               state_d = I_FILL;
            end else if (d_req && d_wr) begin
               state_d = D_WRITE;
            end else if (d_req) begin
               state_d = D_FILL;
            end
         end
         I_FILL, D_FILL: begin
            if (fill_done) begin
               state_d = IDLE;
            end
         end
         D_WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Returning data is only attributed to an owner while a fill is in flight.
   always_comb begin
      mem_en        = 1'b0;
      mem_wr        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      i_data_valid  = 1'b0;
      d_data_valid  = 1'b0;
      i_done        = 1'b0;
      d_done        = 1'b0;
      waitForICACHE = 1'b0;
      unique case (state_q)
         IDLE: begin
            waitForICACHE = i_req;
         end
         I_FILL: begin
            waitForICACHE = 1'b1;
            mem_en        = issuing;
            mem_addr      = issuing ? {base_q, ic[IDXW-1:0], 1'b0} : 16'h0000;
            i_data_valid  = mem_data_valid;
            i_done        = fill_done;
         end
         D_FILL: begin
            mem_en        = issuing;
            mem_addr      = issuing ? {base_q, ic[IDXW-1:0], 1'b0} : 16'h0000;
            d_data_valid  = mem_data_valid;
            d_done        = fill_done;
         end
         D_WRITE: begin
            mem_en        = 1'b1;
            mem_wr        = 1'b1;
            mem_addr      = d_addr;
            mem_wdata     = d_wdata;
            d_done        = 1'b1;
         end
         default: begin
            mem_en        = 1'b0;
         end
      endcase
   end

   assign rd_data  = mem_rdata;
   assign word_idx = 3'(rc);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

   localparam int L = 4;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] mem_rdata;
   logic        mem_data_valid;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] rd_data;
   logic [2:0]  word_idx;
   logic        i_data_valid;
   logic        d_data_valid;
   logic        i_done;
   logic        d_done;
   logic        waitForICACHE;

   int checks = 0;
   int errors = 0;

   logic        spur;
   logic        model_valid;
   logic [15:0] model_rdata;
   logic        cap_v;
   logic [15:0] cap_a;
   logic        pipe_v [L];
   logic [15:0] pipe_a [L];

   mem_arbiter #(.MEM_LATENCY(L), .WORDS(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .d_req          (d_req),
      .d_wr           (d_wr),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .rd_data        (rd_data),
      .word_idx       (word_idx),
      .i_data_valid   (i_data_valid),
      .d_data_valid   (d_data_valid),
      .i_done         (i_done),
      .d_done         (d_done),
      .waitForICACHE  (waitForICACHE)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   // Memory model: a read seen in cycle k returns in cycle k+L.
   initial begin
      for (int i = 0; i < L; i++) begin
         pipe_v[i] = 1'b0;
         pipe_a[i] = 16'h0000;
      end
      cap_v       = 1'b0;
      cap_a       = 16'h0000;
      model_valid = 1'b0;
      model_rdata = 16'h0000;
   end

   always @(negedge clk) begin
      cap_v = mem_en & ~mem_wr;
      cap_a = mem_addr;
   end

   always @(posedge clk) begin
      #1;
      for (int i = L - 1; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0]   = cap_v;
      pipe_a[0]   = cap_a;
      model_valid = pipe_v[L-1];
      model_rdata = pipe_v[L-1] ? memWord(pipe_a[L-1]) : 16'h0000;
   end

   assign mem_data_valid = model_valid | spur;
   assign mem_rdata      = model_rdata;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr,
                                input logic dw, input logic [15:0] da, input logic [15:0] dd);
      i_req   = ir;
      i_addr  = ia;
      d_req   = dr;
      d_wr    = dw;
      d_addr  = da;
      d_wdata = dd;
   endtask

   // Entered in the arbitration cycle t with the request already driven.
   task automatic runFill(input string tag, input bit owner_i, input logic [15:0] base, input int raise_k);
      logic exp_v;
      int   idx;
      @(negedge clk);
      checkOutput({tag, "_idle_en"}, 16'(mem_en), 16'h0);
      checkOutput({tag, "_idle_wait"}, 16'(waitForICACHE), 16'(i_req));
      for (int k = 1; k <= 8 + L; k++) begin
         @(posedge clk); #1;
         if (k == raise_k) i_req = 1'b1;
         @(negedge clk);
         exp_v = (k >= 1 + L);
         idx   = k - 1 - L;
         checkOutput({tag, "_en"}, 16'(mem_en), 16'(k <= 8));
         checkOutput({tag, "_wr"}, 16'(mem_wr), 16'h0);
         if (k <= 8) checkOutput({tag, "_addr"}, mem_addr, base + 16'(2 * (k - 1)));
         checkOutput({tag, "_wait"}, 16'(waitForICACHE), 16'(owner_i));
         checkOutput({tag, "_ivalid"}, 16'(i_data_valid), 16'(owner_i & exp_v));
         checkOutput({tag, "_dvalid"}, 16'(d_data_valid), 16'(!owner_i & exp_v));
         if (exp_v) begin
            checkOutput({tag, "_widx"}, 16'(word_idx), 16'(idx));
            checkOutput({tag, "_rdata"}, rd_data, memWord(base + 16'(2 * idx)));
         end
         checkOutput({tag, "_idone"}, 16'(i_done), 16'(owner_i && k == 8 + L));
         checkOutput({tag, "_ddone"}, 16'(d_done), 16'(!owner_i && k == 8 + L));
      end
      @(posedge clk); #1;
      if (owner_i) i_req = 1'b0;
      else         d_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int late;
      rst_n = 1'b0;
      spur  = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #3;
      checkOutput("rst_en",    16'(mem_en), 16'h0);
      checkOutput("rst_wr",    16'(mem_wr), 16'h0);
      checkOutput("rst_addr",  mem_addr, 16'h0000);
      checkOutput("rst_wdata", mem_wdata, 16'h0000);
      checkOutput("rst_widx",  16'(word_idx), 16'h0);
      checkOutput("rst_ivld",  16'(i_data_valid), 16'h0);
      checkOutput("rst_dvld",  16'(d_data_valid), 16'h0);
      checkOutput("rst_idone", 16'(i_done), 16'h0);
      checkOutput("rst_ddone", 16'(d_done), 16'h0);
      checkOutput("rst_wait",  16'(waitForICACHE), 16'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Spurious returns while idle must be ignored and not counted.
      spur = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("spur_ivalid", 16'(i_data_valid), 16'h0);
         checkOutput("spur_dvalid", 16'(d_data_valid), 16'h0);
         checkOutput("spur_widx",   16'(word_idx), 16'h0);
         @(posedge clk); #1;
      end
      spur = 1'b0;

      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000);
      runFill("ifill", 1'b1, 16'h1230, 0);

      applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h8000, 16'h0000);
      runFill("both_i", 1'b1, 16'h0040, 0);
      runFill("both_d", 1'b0, 16'h8000, 0);

      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A2, 16'hBEEF);
      @(negedge clk);
      checkOutput("wr_idle_en", 16'(mem_en), 16'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("wr_en",    16'(mem_en), 16'h1);
      checkOutput("wr_wr",    16'(mem_wr), 16'h1);
      checkOutput("wr_addr",  mem_addr, 16'h00A2);
      checkOutput("wr_wdata", mem_wdata, 16'hBEEF);
      checkOutput("wr_ddone", 16'(d_done), 16'h1);
      @(posedge clk); #1;
      d_req = 1'b0;
      d_wr  = 1'b0;
      @(negedge clk);
      checkOutput("wr_after_en",    16'(mem_en), 16'h0);
      checkOutput("wr_after_ddone", 16'(d_done), 16'h0);
      @(posedge clk); #1;

      applyStimulus(1'b0, 16'h3338, 1'b1, 1'b0, 16'h2200, 16'h0000);
      runFill("nopre_d", 1'b0, 16'h2200, 1 + L + 3);
      runFill("nopre_i", 1'b1, 16'h3330, 0);

      // Reset in the middle of the I-fill return phase, at word 2.
      applyStimulus(1'b1, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h0000);
      for (int k = 1; k <= 1 + L + 2; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkOutput("prerst_ivalid", 16'(i_data_valid), 16'h1);
      checkOutput("prerst_widx",   16'(word_idx), 16'h2);
      #1;
      rst_n = 1'b0;
      i_req = 1'b0;
      #1;
      checkOutput("midrst_en",     16'(mem_en), 16'h0);
      checkOutput("midrst_addr",   mem_addr, 16'h0000);
      checkOutput("midrst_ivalid", 16'(i_data_valid), 16'h0);
      checkOutput("midrst_widx",   16'(word_idx), 16'h0);
      checkOutput("midrst_wait",   16'(waitForICACHE), 16'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      late  = 0;
      repeat (L + 8) begin
         @(negedge clk);
         if (i_data_valid || d_data_valid) late++;
         @(posedge clk); #1;
      end
      checkOutput("rst_late_valid", 16'(late), 16'h0);

      applyStimulus(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0000, 16'h0000);
      runFill("after_rst", 1'b1, 16'h0500, 0);
      @(negedge clk);
      checkOutput("end_en",   16'(mem_en), 16'h0);
      checkOutput("end_wait", 16'(waitForICACHE), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
